// File: rtl/tlb_wr_ctrl.sv
// tlb_wr_ctrl: single write port arbiter for the TLB RAM.
// It serves software writes, walker fills and invalidate-all sweeps.
module tlb_wr_ctrl #(
    parameter int TLB_ASSOC   = 4,
    parameter int TLB_ENTRIES = 1024,
    parameter int ENTRY_W     = $clog2(TLB_ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_req,
    input  logic [127:0]         sw_entry,
    input  logic [15:0]          sw_entry_no,
    input  logic [7:0]           sw_way,
    output logic                 sw_ack,
    output logic                 sw_err,
    input  logic                 fill_req,
    input  logic [127:0]         fill_entry,
    input  logic [ENTRY_W-1:0]   fill_idx,
    output logic                 fill_ack,
    output logic [7:0]           fill_way,
    input  logic                 inv_req,
    output logic                 inv_done,
    output logic                 wr_en,
    output logic [TLB_ASSOC-1:0] wr_way,
    output logic [ENTRY_W-1:0]   wr_adr,
    output logic [127:0]         wr_dat,
    output logic                 busy
);
    localparam int VW = $clog2(TLB_ASSOC);
    typedef enum logic [1:0] {IDLE, WRITE, SWEEP, DONE} state_t;
    state_t               r_state;
    logic [VW-1:0]        r_victim;
    logic                 r_rr;
    logic                 w_sw_err;
    logic                 w_gnt_sw;
    logic                 w_gnt_fill;
    logic [TLB_ASSOC-1:0] w_sw_oh;
    logic [TLB_ASSOC-1:0] w_fill_oh;
    assign w_sw_err   = 32'(sw_entry_no) >= TLB_ENTRIES || 32'(sw_way) >= TLB_ASSOC;
    // r_rr set means sw was granted last, so a contending fill wins next
    assign w_gnt_sw   = !inv_req && sw_req && (!fill_req || !r_rr);
    assign w_gnt_fill = !inv_req && fill_req && !w_gnt_sw;
    assign w_sw_oh    = TLB_ASSOC'(1) << sw_way;
    assign w_fill_oh  = TLB_ASSOC'(1) << r_victim;
    // wr_adr doubles as the sweep counter while in SWEEP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_victim <= '0;
            r_rr     <= 1'b0;
            sw_ack   <= 1'b0;
            sw_err   <= 1'b0;
            fill_ack <= 1'b0;
            fill_way <= '0;
            inv_done <= 1'b0;
            wr_en    <= 1'b0;
            wr_way   <= '0;
            wr_adr   <= '0;
            wr_dat   <= '0;
            busy     <= 1'b0;
        end else begin
            sw_ack   <= 1'b0;
            sw_err   <= 1'b0;
            fill_ack <= 1'b0;
            fill_way <= '0;
            inv_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (inv_req) begin
                        r_state <= SWEEP;
                        busy    <= 1'b1;
                        wr_en   <= 1'b1;
                        wr_way  <= '1;
                        wr_adr  <= '0;
                        wr_dat  <= '0;
                    end else if (w_gnt_sw) begin
                        r_state <= WRITE;
                        busy    <= 1'b1;
                        r_rr    <= 1'b1;
                        sw_ack  <= 1'b1;
                        sw_err  <= w_sw_err;
                        wr_en   <= !w_sw_err;
                        wr_way  <= w_sw_err ? '0 : w_sw_oh;
                        wr_adr  <= w_sw_err ? '0 : sw_entry_no[ENTRY_W-1:0];
                        wr_dat  <= w_sw_err ? '0 : sw_entry;
                    end else if (w_gnt_fill) begin
                        r_state  <= WRITE;
                        busy     <= 1'b1;
                        r_rr     <= 1'b0;
                        fill_ack <= 1'b1;
                        fill_way <= 8'(r_victim);
                        r_victim <= r_victim == VW'(TLB_ASSOC - 1) ? '0 : r_victim + VW'(1);
                        wr_en    <= 1'b1;
                        wr_way   <= w_fill_oh;
                        wr_adr   <= fill_idx;
                        wr_dat   <= fill_entry;
                    end
                end
                WRITE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                    wr_en   <= 1'b0;
                    wr_way  <= '0;
                    wr_adr  <= '0;
                    wr_dat  <= '0;
                end
                SWEEP: begin
                    if (wr_adr == ENTRY_W'(TLB_ENTRIES - 1)) begin
                        r_state  <= DONE;
                        inv_done <= 1'b1;
                        wr_en    <= 1'b0;
                        wr_way   <= '0;
                        wr_adr   <= '0;
                    end else begin
                        wr_adr <= wr_adr + ENTRY_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlb_wr_ctrl.sv
// tb_tlb_wr_ctrl: directed and random stimulus for tlb_wr_ctrl, checked every cycle
// against a transaction model that schedules the expected output beats in a queue.
module tb_tlb_wr_ctrl;
    localparam int A  = 4;
    localparam int N  = 1024;
    localparam int EW = 10;
    localparam int CW = 160;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw_req = 1'b0;
    logic [127:0]  sw_entry = '0;
    logic [15:0]   sw_entry_no = '0;
    logic [7:0]    sw_way = '0;
    logic          sw_ack, sw_err;
    logic          fill_req = 1'b0;
    logic [127:0]  fill_entry = '0;
    logic [EW-1:0] fill_idx = '0;
    logic          fill_ack;
    logic [7:0]    fill_way;
    logic          inv_req = 1'b0;
    logic          inv_done, wr_en, busy;
    logic [A-1:0]  wr_way;
    logic [EW-1:0] wr_adr;
    logic [127:0]  wr_dat;
    int            checks = 0;
    int            errors = 0;
    typedef struct packed {
        logic          wr_en;
        logic [A-1:0]  way;
        logic [EW-1:0] adr;
        logic [127:0]  dat;
        logic          sw_ack;
        logic          sw_err;
        logic          fill_ack;
        logic [7:0]    fill_way;
        logic          inv_done;
        logic          busy;
    } beat_t;
    beat_t         q[$];
    beat_t         exp_b = '0;
    beat_t         got_b;
    bit            last_sw = 1'b0;
    int            fills = 0;
    logic [3:0]    fw_way [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [127:0]  x;
    int            cnt;

    assign got_b = {wr_en, wr_way, wr_adr, wr_dat, sw_ack, sw_err, fill_ack, fill_way, inv_done, busy};

    tlb_wr_ctrl #(.TLB_ASSOC(A), .TLB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst),
        .sw_req(sw_req), .sw_entry(sw_entry), .sw_entry_no(sw_entry_no), .sw_way(sw_way),
        .sw_ack(sw_ack), .sw_err(sw_err),
        .fill_req(fill_req), .fill_entry(fill_entry), .fill_idx(fill_idx),
        .fill_ack(fill_ack), .fill_way(fill_way),
        .inv_req(inv_req), .inv_done(inv_done),
        .wr_en(wr_en), .wr_way(wr_way), .wr_adr(wr_adr), .wr_dat(wr_dat), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // a grant books its whole future: one beat per output cycle plus the idle turnaround cycle
    task automatic model_step();
        beat_t b;
        if (!rst) begin
            q.delete();
            last_sw = 1'b0;
            fills   = 0;
            exp_b   = '0;
            return;
        end
        if (q.size() == 0) begin
            if (inv_req) begin
                for (int i = 0; i < N; i++) begin
                    b = '0; b.wr_en = 1'b1; b.way = '1; b.adr = EW'(i); b.busy = 1'b1;
                    q.push_back(b);
                end
                b = '0; b.inv_done = 1'b1; b.busy = 1'b1;
                q.push_back(b);
                b = '0;
                q.push_back(b);
            end else if (sw_req || fill_req) begin
                b = '0; b.busy = 1'b1;
                if (sw_req && (!fill_req || !last_sw)) begin
                    last_sw  = 1'b1;
                    b.sw_ack = 1'b1;
                    if (int'(sw_entry_no) >= N || int'(sw_way) >= A) b.sw_err = 1'b1;
                    else begin
                        b.wr_en = 1'b1;
                        b.way[sw_way[1:0]] = 1'b1;
                        b.adr = sw_entry_no[EW-1:0];
                        b.dat = sw_entry;
                    end
                end else begin
                    last_sw    = 1'b0;
                    b.fill_ack = 1'b1;
                    b.fill_way = 8'(fills % A);
                    b.wr_en    = 1'b1;
                    b.way[fills % A] = 1'b1;
                    b.adr      = fill_idx;
                    b.dat      = fill_entry;
                    fills++;
                end
                q.push_back(b);
                b = '0;
                q.push_back(b);
            end
        end
        exp_b = (q.size() != 0) ? q.pop_front() : '0;
    endtask

    // requesters hold their request until they see the matching completion
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk(tag, CW'(got_b), CW'(exp_b));
        if (sw_ack) sw_req = 1'b0;
        if (fill_ack) fill_req = 1'b0;
        if (inv_done) inv_req = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        q.delete();
        last_sw = 1'b0;
        fills   = 0;
        exp_b   = '0;
        #1 chk("async_rst", CW'(got_b), '0);
        cycle("in_rst");
        cycle("in_rst");
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 chk("reset", CW'(got_b), '0);
        cycle("rst");
        cycle("rst");
        rst = 1'b1;
        cycle("idle");
        x = r128();
        sw_req = 1'b1; sw_entry_no = 16'd5; sw_way = 8'd2; sw_entry = x;
        cycle("sw5");
        chk("sw5_en", CW'(wr_en), CW'(1));
        chk("sw5_way", CW'(wr_way), CW'(4'b0100));
        chk("sw5_adr", CW'(wr_adr), CW'(5));
        chk("sw5_dat", CW'(wr_dat), CW'(x));
        chk("sw5_ack", CW'({sw_ack, sw_err}), CW'(2'b10));
        cycle("sw5_gap");
        chk("sw5_clr", CW'({wr_en, wr_way, wr_adr, wr_dat, sw_ack}), '0);
        sw_req = 1'b1; sw_entry_no = 16'd7; sw_way = 8'd4; sw_entry = r128();
        cycle("bad_way");
        chk("bad_way_o", CW'({sw_ack, sw_err, wr_en}), CW'(3'b110));
        cycle("gap");
        sw_req = 1'b1; sw_entry_no = 16'd1024; sw_way = 8'd1;
        cycle("bad_no");
        chk("bad_no_o", CW'({sw_ack, sw_err, wr_en}), CW'(3'b110));
        cycle("gap");
        sw_req = 1'b1; sw_entry_no = 16'd1023; sw_way = 8'd3;
        cycle("top_no");
        chk("top_no_o", CW'({sw_ack, sw_err, wr_en, wr_way, wr_adr}), CW'({3'b101, 4'b1000, 10'd1023}));
        cycle("gap");
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fill_req = 1'b1; fill_idx = EW'($urandom_range(N - 1)); fill_entry = r128();
            cycle("fill");
            chk("fill_way", CW'({fill_ack, fill_way}), CW'({1'b1, 8'(i % A)}));
            chk("fill_oh", CW'(wr_way), CW'(fw_way[i]));
            cycle("fill_gap");
        end
        sw_req = 1'b1; sw_entry_no = 16'd9; sw_way = 8'd1;
        fill_req = 1'b1; fill_idx = 10'd7;
        do_reset();
        cycle("both");
        chk("both_sw", CW'({sw_ack, fill_ack}), CW'(2'b10));
        cycle("both_gap");
        cycle("both2");
        chk("both_fill", CW'({sw_ack, fill_ack}), CW'(2'b01));
        for (int g = 0; g < 4; g++) begin
            sw_req = 1'b1; fill_req = 1'b1;
            cycle("alt_gap");
            cycle("alt");
            chk("alt_order", CW'({sw_ack, fill_ack}), (g % 2 == 0) ? CW'(2'b10) : CW'(2'b01));
        end
        sw_req = 1'b0; fill_req = 1'b0;
        cycle("gap");
        cycle("gap");
        inv_req = 1'b1;
        cycle("sweep");
        chk("sweep0", CW'({wr_en, wr_way, wr_adr, wr_dat}), CW'({1'b1, 4'b1111, 10'd0, 128'd0}));
        cnt = 1;
        sw_req = 1'b1; sw_entry_no = 16'd33; sw_way = 8'd0; sw_entry = r128();
        for (int i = 0; i < N - 1; i++) begin
            cycle("sweep");
            if (wr_en && wr_way == 4'b1111 && wr_dat == '0) cnt++;
        end
        chk("sweep_cnt", CW'(cnt), CW'(N));
        cycle("done");
        chk("inv_done", CW'({inv_done, wr_en}), CW'(2'b10));
        cycle("post_done");
        chk("post_done", CW'({sw_ack, busy}), '0);
        cycle("pend_sw");
        chk("pend_sw", CW'(sw_ack), CW'(1));
        cycle("gap");
        inv_req = 1'b1;
        for (int i = 0; i < 400 && !(wr_en && wr_adr == 10'd300); i++) cycle("sweep2");
        chk("adr300", CW'(wr_adr), CW'(300));
        inv_req = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle("no_done");
            chk("no_done", CW'({inv_done, busy}), '0);
        end
        inv_req = 1'b1;
        cycle("resweep");
        chk("resweep0", CW'({wr_en, wr_adr}), CW'({1'b1, 10'd0}));
        cnt = 0;
        for (int i = 0; i < 1100 && cnt == 0; i++) begin
            cycle("resweep");
            if (inv_done) cnt = 1;
        end
        chk("resweep_done", CW'(cnt), CW'(1));
        for (int c = 0; c < 3000; c++) begin
            if (!sw_req && $urandom_range(3) == 0) begin
                sw_req = 1'b1;
                sw_entry = r128();
                sw_entry_no = ($urandom_range(7) == 0) ? 16'(N + $urandom_range(2000)) : 16'($urandom_range(N - 1));
                sw_way = 8'($urandom_range(4));
            end else if (sw_req && $urandom_range(15) == 0) sw_req = 1'b0;
            if (!fill_req && $urandom_range(3) == 0) begin
                fill_req = 1'b1;
                fill_entry = r128();
                fill_idx = EW'($urandom_range(N - 1));
            end else if (fill_req && $urandom_range(15) == 0) fill_req = 1'b0;
            if (!inv_req && $urandom_range(599) == 0) inv_req = 1'b1;
            cycle("rand");
        end
        sw_req = 1'b0; fill_req = 1'b0;
        for (int i = 0; i < 1100 && busy; i++) cycle("drain");
        chk("drained", CW'(busy), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlb_wr_ctrl.md
TLB_WR_CTRL -- requirements
Module: tlb_wr_ctrl

Interface
REQ-001 Parameters SHALL be:
- TLB_ASSOC, 4, number of ways
- TLB_ENTRIES, 1024, entries per way (power of two)
- ENTRY_W, $clog2(TLB_ENTRIES), entry index width
REQ-002 Ports SHALL be:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- sw_req  in  1  software write request, held until sw_ack
- sw_entry  in  128  tlb_entry_t from bus-interface hold register
- sw_entry_no  in  16  target entry index
- sw_way  in  8  target way number
- sw_ack  out  1  one-cycle completion pulse
- sw_err  out  1  valid with sw_ack; request rejected
- fill_req  in  1  walker fill request, held until fill_ack
- fill_entry  in  128  tlb_entry_t to install
- fill_idx  in  ENTRY_W  target entry index
- fill_ack  out  1  one-cycle completion pulse
- fill_way  out  8  way used, valid with fill_ack
- inv_req  in  1  invalidate-all request, held until inv_done
- inv_done  out  1  one-cycle pulse after sweep completes
- wr_en  out  1  TLB RAM write strobe
- wr_way  out  TLB_ASSOC  one-hot or all-ones way enable
- wr_adr  out  ENTRY_W  RAM entry index
- wr_dat  out  128  RAM write data
- busy  out  1  state not IDLE

Function
REQ-003 FSM states SHALL be IDLE, WRITE, SWEEP, DONE; exactly one write source serviced at a time.
REQ-004 In IDLE, arbitration priority SHALL be inv_req first, then round-robin between sw_req and fill_req.
REQ-005 Round-robin pointer SHALL favour the requester not granted last; it updates only on a sw or fill grant.
REQ-006 On a sw or fill grant, the FSM SHALL go to WRITE and latch the data, index and way in the grant cycle.
REQ-007 In WRITE, the block SHALL drive wr_en=1, wr_adr, wr_dat and wr_way for exactly one cycle, assert the matching ack in the same cycle, then return to IDLE.
- Request to write strobe/ack latency is 1 cycle.
- Minimum spacing between back-to-back grants is 2 cycles.
REQ-008 sw_entry_no >= TLB_ENTRIES or sw_way >= TLB_ASSOC SHALL produce sw_ack=1, sw_err=1 and wr_en=0 in the WRITE cycle.
REQ-009 The sw write index SHALL be sw_entry_no[ENTRY_W-1:0]; wr_way SHALL be the one-hot decode of sw_way.
REQ-010 Fill victim way SHALL come from a 2-bit-wide (log2 TLB_ASSOC) victim counter.
- Counter increments modulo TLB_ASSOC after each fill write.
- Counter wraps from TLB_ASSOC-1 to 0.
- fill_way reports the pre-increment value.
REQ-011 On an inv_req grant, the FSM SHALL enter SWEEP with the sweep counter at 0.
- Each SWEEP cycle: wr_en=1, wr_way all-ones, wr_dat=0, wr_adr=sweep counter.
- Counter increments each cycle.
- After index TLB_ENTRIES-1 the FSM goes to DONE.
REQ-012 DONE SHALL last one cycle with inv_done=1, then return to IDLE.
REQ-013 sw_req and fill_req arriving during SWEEP or DONE SHALL remain pending and be arbitrated in the next IDLE.
REQ-014 A request deasserted before grant SHALL be dropped with no ack.
REQ-015 When not writing, wr_en SHALL be 0, and wr_way, wr_adr and wr_dat SHALL be 0.
REQ-016 busy SHALL be 1 in WRITE, SWEEP and DONE.

Reset
REQ-017 rst=0 SHALL immediately force the following, including mid-sweep and mid-write:
- state IDLE
- all outputs 0
- victim counter, sweep counter and round-robin pointer 0 (sw favoured first)
- no inv_done for an aborted sweep
REQ-018 After rst deasserts, the first arbitration SHALL occur on the first rising edge with rst=1.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- SW write: sw_entry_no=5, sw_way=2, sw_entry=X -> next cycle wr_en=1, wr_way=4'b0100, wr_adr=5, wr_dat=X, sw_ack=1, sw_err=0.
- SW out-of-range: sw_way=4 -> sw_ack=1, sw_err=1, wr_en=0; same with sw_entry_no=1024.
- Fill victim wrap: five consecutive fills -> fill_way 0,1,2,3,0; wr_way one-hot to match.
- Simultaneous sw_req and fill_req held from reset -> sw acked first, fill acked 2 cycles later; repeat with both held -> order alternates.
- Invalidate: inv_req with sw_req asserted one cycle later -> 1024 cycles wr_en=1, wr_way=4'b1111, wr_dat=0, wr_adr 0..1023; inv_done pulse; sw_ack 2 cycles after inv_done.
- Reset mid-sweep at wr_adr=300 -> outputs 0 asynchronously, no inv_done; re-issued inv_req restarts at wr_adr=0.
